pipelined_control_unit: RTL
===========================

Name: pipelined_control_unit

Overview:
- Next-generation RV32I control unit for the 5-stage pipelined core.
- Decodes in D and carries the control bundle through registered D→E, E→M and M→W stages.
- Resolves all six branch conditions, plus JAL and JALR, in E.
- Handles stall and flush bubbles from the hazard unit.
- Replaces the single-cycle decoder. Its outputs feed the datapath stage registers, the immediate extender and the hazard unit.

Parameters:
- DATA_WIDTH, 32, instruction width (only [31:0] decoded).
- ALUCTRL_WIDTH, 4, width of the ALU control code.
- REG_ADDR_WIDTH, 5, destination register address width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_d  in  DATA_WIDTH  instruction in Decode.
- valid_d  in  1  instr_d is a real instruction (0 = bubble).
- stall_e  in  1  load-use stall: E captures a bubble.
- flush_e  in  1  taken-branch flush: E captures a bubble.
- zero_e  in  1  ALU result == 0.
- lt_e  in  1  signed rs1 < rs2.
- ltu_e  in  1  unsigned rs1 < rs2.
- ImmSrc_d  out  3  immediate format, combinational from instr_d.
- ALUctrl_e  out  ALUCTRL_WIDTH  ALU operation.
- ALUSrc_e  out  1  ALU B operand: 1 = immediate.
- PCSrc_e  out  2  next PC: 00 = PC+4, 01 = PC+imm, 10 = rs1+imm.
- ResultSrc_e  out  2  E-stage copy, used for load detection.
- rd_e / rd_m / rd_w  out  REG_ADDR_WIDTH  destination register per stage.
- RegWrite_m / RegWrite_w  out  1  register write enable per stage.
- MemWrite_m  out  1  data memory write.
- funct3_m  out  3  access size and sign for the memory stage.
- ResultSrc_w  out  2  writeback mux select: 00 = ALU, 01 = memory, 10 = PC+4.

Behaviour:
- Opcodes decoded:
  - R 0110011
  - I-ALU 0010011
  - load 0000011
  - store 0100011
  - branch 1100011
  - jal 1101111
  - jalr 1100111
  - lui 0110111
- ImmSrc encoding: I = 000, S = 001, B = 010, J = 011, U = 100. Don't-care returns 000.
- ALUctrl encoding: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001, passB 1010.
- ALUctrl selection:
  - funct3 = 000: sub only for R-type with instr[30] = 1; otherwise add.
  - funct3 = 101: sra when instr[30] = 1, for both R-type and I-ALU.
  - Loads, stores, jal and jalr use add.
  - Branches use sub.
  - lui uses passB.
- Illegal opcode or valid_d = 0: bundle = bubble (all write enables 0, PCSrc 00).
- Stage registers:
  - D→E, E→M and M→W update every cycle. There is no stage hold.
  - Control is visible in E exactly one cycle after decode in D, in M after 2 cycles, and in W after 3 cycles.
- E capture priority: stall_e or flush_e → bubble; otherwise the decoded bundle. If both are asserted, the result is a single bubble.
- PCSrc_e, combinational from the E bundle and the flags:
  - jal → 01.
  - jalr → 10.
  - Branch taken per funct3 → 01:
    - beq: zero_e
    - bne: !zero_e
    - blt: lt_e
    - bge: !lt_e
    - bltu: ltu_e
    - bgeu: !ltu_e
  - Branch funct3 010 or 011 → 00.
  - A bubble in E → 00.
- rd is forced to 0 for store and branch, so that hazard comparisons never match.
- Reset (asynchronous, rst_n low): all stage registers clear to bubble. All registered outputs read 0, including rd, ResultSrc, funct3 and ALUctrl. Release is synchronous to the next clk edge. Reset asserted mid-pipeline discards in-flight control.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- When defined:
  - Adds output illegal_o (1 bit), sticky.
  - Set one cycle after an illegal opcode with valid_d = 1 is captured into E (not a bubble).
  - Cleared only by rst_n.
- When undefined: the port is absent and illegal opcodes decode silently as bubbles.

Test Plan:
- Reset then idle: rst_n = 0 mid-stream → all outputs 0 immediately; PCSrc_e = 00; RegWrite_w = 0 for 3 cycles after release with valid_d = 0.
- add x5,x1,x2 (0x002082B3), valid_d = 1 → next cycle ALUctrl_e = 0000, ALUSrc_e = 0, rd_e = 5; cycle +3: RegWrite_w = 1, ResultSrc_w = 00, rd_w = 5.
- sub / sra / srai: 0x40208033 → ALUctrl_e = 0001; 0x4020D033 → 1001; 0x4030D093 → 1001, ALUSrc_e = 1.
- Branches: bne (funct3 001) with zero_e = 0 → PCSrc_e = 01; with zero_e = 1 → 00. bgeu with ltu_e = 1 → 00. jalr (0x000080E7) → 10 and ResultSrc_w = 10 three cycles later.
- lw x3,0(x1) (0x0000A183): ResultSrc_e = 01 and RegWrite_m = 1 at cycle +2. With stall_e = 1 and flush_e = 1 in the same cycle → E bubble: ALUctrl_e = 0000, PCSrc_e = 00, rd_e = 0.
- With CTRL_ILLEGAL_TRAP_EN: instr 0x0000007F, valid_d = 1 → illegal_o = 1 two edges later and stays 1; a bubble with valid_d = 0 and the same instr leaves it at 0.

Source files
------------

// File: rtl/pipelined_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipelined_control_unit                                        |
// | Desc     : RV32I decode in D with registered D->E->M->W control bundle;  |
// |            branch/jump resolution in E. Optional macro                   |
// |            CTRL_ILLEGAL_TRAP_EN adds the sticky illegal_o output.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pipelined_control_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALUCTRL_WIDTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     instr_d,
  input  logic                      valid_d,
  input  logic                      stall_e,
  input  logic                      flush_e,
  input  logic                      zero_e,
  input  logic                      lt_e,
  input  logic                      ltu_e,
  output logic [2:0]                ImmSrc_d,
  output logic [ALUCTRL_WIDTH-1:0]  ALUctrl_e,
  output logic                      ALUSrc_e,
  output logic [1:0]                PCSrc_e,
  output logic [1:0]                ResultSrc_e,
  output logic [REG_ADDR_WIDTH-1:0] rd_e,
  output logic [REG_ADDR_WIDTH-1:0] rd_m,
  output logic [REG_ADDR_WIDTH-1:0] rd_w,
  output logic                      RegWrite_m,
  output logic                      RegWrite_w,
  output logic                      MemWrite_m,
  output logic [2:0]                funct3_m,
  output logic [1:0]                ResultSrc_w
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                      illegal_o
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD   = ALUCTRL_WIDTH'(4'b0000);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB   = ALUCTRL_WIDTH'(4'b0001);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_AND   = ALUCTRL_WIDTH'(4'b0010);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_OR    = ALUCTRL_WIDTH'(4'b0011);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_XOR   = ALUCTRL_WIDTH'(4'b0100);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLT   = ALUCTRL_WIDTH'(4'b0101);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLTU  = ALUCTRL_WIDTH'(4'b0110);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLL   = ALUCTRL_WIDTH'(4'b0111);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SRL   = ALUCTRL_WIDTH'(4'b1000);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SRA   = ALUCTRL_WIDTH'(4'b1001);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_PASSB = ALUCTRL_WIDTH'(4'b1010);

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       bit30;

  assign opcode = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign bit30  = instr_d[30];

  function automatic logic [ALUCTRL_WIDTH-1:0] alu_op(input logic [2:0] f3,
                                                      input logic       b30,
                                                      input logic       is_r);
    case (f3)
      3'b000:  alu_op = (is_r && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  logic [2:0] imm_src_d;

  always_comb begin
    case (opcode)
      OP_STORE:  imm_src_d = IMM_S;
      OP_BRANCH: imm_src_d = IMM_B;
      OP_JAL:    imm_src_d = IMM_J;
      OP_LUI:    imm_src_d = IMM_U;
      default:   imm_src_d = IMM_I;
    endcase
  end

  logic [ALUCTRL_WIDTH-1:0]  dec_alu_ctrl;
  logic                      dec_alu_src;
  logic [1:0]                dec_result_src;
  logic                      dec_reg_write;
  logic                      dec_mem_write;
  logic                      dec_branch;
  logic                      dec_jal;
  logic                      dec_jalr;
  logic [REG_ADDR_WIDTH-1:0] dec_rd;
  logic                      dec_known;

  always_comb begin
    dec_alu_ctrl   = ALU_ADD;
    dec_alu_src    = 1'b0;
    dec_result_src = RES_ALU;
    dec_reg_write  = 1'b0;
    dec_mem_write  = 1'b0;
    dec_branch     = 1'b0;
    dec_jal        = 1'b0;
    dec_jalr       = 1'b0;
    dec_rd         = REG_ADDR_WIDTH'(instr_d[11:7]);
    dec_known      = 1'b1;
    case (opcode)
      OP_R: begin
        dec_alu_ctrl  = alu_op(funct3, bit30, 1'b1);
        dec_reg_write = 1'b1;
      end
      OP_I: begin
        dec_alu_ctrl  = alu_op(funct3, bit30, 1'b0);
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      OP_LOAD: begin
        dec_alu_src    = 1'b1;
        dec_result_src = RES_MEM;
        dec_reg_write  = 1'b1;
      end
      // Stores and branches never write rd; zeroing it keeps hazard compares quiet.
      OP_STORE: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
        dec_rd        = '0;
      end
      OP_BRANCH: begin
        dec_alu_ctrl = ALU_SUB;
        dec_branch   = 1'b1;
        dec_rd       = '0;
      end
      OP_JAL: begin
        dec_result_src = RES_PC4;
        dec_reg_write  = 1'b1;
        dec_jal        = 1'b1;
      end
      OP_JALR: begin
        dec_alu_src    = 1'b1;
        dec_result_src = RES_PC4;
        dec_reg_write  = 1'b1;
        dec_jalr       = 1'b1;
      end
      OP_LUI: begin
        dec_alu_ctrl  = ALU_PASSB;
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      default: dec_known = 1'b0;
    endcase
  end

  // E stage
  logic                      kill_e;
  logic [ALUCTRL_WIDTH-1:0]  alu_ctrl_e_d, alu_ctrl_e_q;
  logic                      alu_src_e_d, alu_src_e_q;
  logic [1:0]                result_src_e_d, result_src_e_q;
  logic                      reg_write_e_d, reg_write_e_q;
  logic                      mem_write_e_d, mem_write_e_q;
  logic                      branch_e_d, branch_e_q;
  logic                      jal_e_d, jal_e_q;
  logic                      jalr_e_d, jalr_e_q;
  logic [REG_ADDR_WIDTH-1:0] rd_e_d, rd_e_q;
  logic [2:0]                funct3_e_d, funct3_e_q;

  assign kill_e = stall_e | flush_e | ~valid_d | ~dec_known;

  always_comb begin
    alu_ctrl_e_d   = '0;
    alu_src_e_d    = 1'b0;
    result_src_e_d = '0;
    reg_write_e_d  = 1'b0;
    mem_write_e_d  = 1'b0;
    branch_e_d     = 1'b0;
    jal_e_d        = 1'b0;
    jalr_e_d       = 1'b0;
    rd_e_d         = '0;
    funct3_e_d     = '0;
    if (!kill_e) begin
      alu_ctrl_e_d   = dec_alu_ctrl;
      alu_src_e_d    = dec_alu_src;
      result_src_e_d = dec_result_src;
      reg_write_e_d  = dec_reg_write;
      mem_write_e_d  = dec_mem_write;
      branch_e_d     = dec_branch;
      jal_e_d        = dec_jal;
      jalr_e_d       = dec_jalr;
      rd_e_d         = dec_rd;
      funct3_e_d     = funct3;
    end
  end

  // M and W stages
  logic [REG_ADDR_WIDTH-1:0] rd_m_d, rd_m_q, rd_w_d, rd_w_q;
  logic                      reg_write_m_d, reg_write_m_q, reg_write_w_d, reg_write_w_q;
  logic                      mem_write_m_d, mem_write_m_q;
  logic [2:0]                funct3_m_d, funct3_m_q;
  logic [1:0]                result_src_m_d, result_src_m_q, result_src_w_d, result_src_w_q;

  always_comb begin
    rd_m_d         = rd_e_q;
    reg_write_m_d  = reg_write_e_q;
    mem_write_m_d  = mem_write_e_q;
    funct3_m_d     = funct3_e_q;
    result_src_m_d = result_src_e_q;
    rd_w_d         = rd_m_q;
    reg_write_w_d  = reg_write_m_q;
    result_src_w_d = result_src_m_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl_e_q   <= '0;
      alu_src_e_q    <= 1'b0;
      result_src_e_q <= '0;
      reg_write_e_q  <= 1'b0;
      mem_write_e_q  <= 1'b0;
      branch_e_q     <= 1'b0;
      jal_e_q        <= 1'b0;
      jalr_e_q       <= 1'b0;
      rd_e_q         <= '0;
      funct3_e_q     <= '0;
      rd_m_q         <= '0;
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      funct3_m_q     <= '0;
      result_src_m_q <= '0;
      rd_w_q         <= '0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= '0;
    end else begin
      alu_ctrl_e_q   <= alu_ctrl_e_d;
      alu_src_e_q    <= alu_src_e_d;
      result_src_e_q <= result_src_e_d;
      reg_write_e_q  <= reg_write_e_d;
      mem_write_e_q  <= mem_write_e_d;
      branch_e_q     <= branch_e_d;
      jal_e_q        <= jal_e_d;
      jalr_e_q       <= jalr_e_d;
      rd_e_q         <= rd_e_d;
      funct3_e_q     <= funct3_e_d;
      rd_m_q         <= rd_m_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_write_m_q  <= mem_write_m_d;
      funct3_m_q     <= funct3_m_d;
      result_src_m_q <= result_src_m_d;
      rd_w_q         <= rd_w_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
    end
  end

  logic [1:0] pc_src_e;

  always_comb begin
    pc_src_e = PC_SEQ;
    if (jal_e_q) begin
      pc_src_e = PC_REL;
    end else if (jalr_e_q) begin
      pc_src_e = PC_REG;
    end else if (branch_e_q) begin
      case (funct3_e_q)
        3'b000:  pc_src_e = zero_e ? PC_REL : PC_SEQ;
        3'b001:  pc_src_e = zero_e ? PC_SEQ : PC_REL;
        3'b100:  pc_src_e = lt_e   ? PC_REL : PC_SEQ;
        3'b101:  pc_src_e = lt_e   ? PC_SEQ : PC_REL;
        3'b110:  pc_src_e = ltu_e  ? PC_REL : PC_SEQ;
        3'b111:  pc_src_e = ltu_e  ? PC_SEQ : PC_REL;
        default: pc_src_e = PC_SEQ;
      endcase
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  // A flagged illegal sits in E for one cycle before the sticky bit sets.
  logic illegal_e_d, illegal_e_q;
  logic illegal_d, illegal_q;

  always_comb begin
    illegal_e_d = valid_d & ~dec_known & ~(stall_e | flush_e);
    illegal_d   = illegal_q | illegal_e_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_e_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      illegal_e_q <= illegal_e_d;
      illegal_q   <= illegal_d;
    end
  end

  assign illegal_o = illegal_q;
`endif

  assign ImmSrc_d    = imm_src_d;
  assign ALUctrl_e   = alu_ctrl_e_q;
  assign ALUSrc_e    = alu_src_e_q;
  assign PCSrc_e     = pc_src_e;
  assign ResultSrc_e = result_src_e_q;
  assign rd_e        = rd_e_q;
  assign rd_m        = rd_m_q;
  assign rd_w        = rd_w_q;
  assign RegWrite_m  = reg_write_m_q;
  assign RegWrite_w  = reg_write_w_q;
  assign MemWrite_m  = mem_write_m_q;
  assign funct3_m    = funct3_m_q;
  assign ResultSrc_w = result_src_w_q;

endmodule
`default_nettype wire
